// File: rtl/rs485_rx_deframer.sv
// RS-485 return-line receiver: UART byte recovery, packet parse, commit FIFO.
// Optional inter-byte timeout (code 5) built when RS485_RX_TIMEOUT_EN is set.
module rs485_rx_deframer #(
  parameter int         BIT_DIV  = 100,
  parameter int         FIFO_AW  = 6,
  parameter int         MAX_LEN  = 32,
  parameter logic [7:0] HDR_BYTE = 8'hA5
) (
  input  logic               clk_sys,
  input  logic               rst_n,
  input  logic               rx_a,
  input  logic               cfg_en,
  output logic [7:0]         dout,
  output logic               dout_eop,
  output logic               dout_vld,
  input  logic               dout_rdy,
  output logic               pkt_ok,
  output logic               pkt_err,
  output logic [2:0]         err_code,
  output logic [FIFO_AW:0]   fifo_cnt
);

  localparam int PW    = FIFO_AW + 1;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam int CW    = $clog2(BIT_DIV);
  localparam logic [CW-1:0] DIV_M1  = CW'(BIT_DIV - 1);
  localparam logic [CW-1:0] HALF_M1 = CW'(BIT_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_st_e;
  typedef enum logic [1:0] {S_HEAD, S_LEN, S_DATA, S_SUM} pkt_st_e;

  logic rx_s1_q, rx_s2_q, rx_p_q;
  logic fall;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1_q <= 1'b1;
      rx_s2_q <= 1'b1;
      rx_p_q  <= 1'b1;
    end else begin
      rx_s1_q <= rx_a;
      rx_s2_q <= rx_s1_q;
      rx_p_q  <= rx_s2_q;
    end
  end

  assign fall = rx_p_q & ~rx_s2_q;

  bit_st_e       bst_q, bst_d;
  logic [CW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shr_q, shr_d;
  logic          byte_vld_q, byte_vld_d;
  logic          ferr;
  logic          tick;

  always_comb begin
    bst_d      = bst_q;
    bcnt_d     = bcnt_q;
    bidx_d     = bidx_q;
    shr_d      = shr_q;
    byte_vld_d = 1'b0;
    ferr       = 1'b0;
    tick       = (bcnt_q == '0);
    if (!cfg_en) begin
      bst_d = IDLE;
    end else begin
      unique case (bst_q)
        IDLE: begin
          if (fall) begin
            bst_d  = START;
            bcnt_d = HALF_M1;
          end
        end
        START: begin
          if (!tick) begin
            bcnt_d = bcnt_q - 1'b1;
          end else if (rx_s2_q) begin
            bst_d = IDLE;
          end else begin
            bst_d  = DATA;
            bcnt_d = DIV_M1;
            bidx_d = 3'd0;
          end
        end
        DATA: begin
          if (!tick) begin
            bcnt_d = bcnt_q - 1'b1;
          end else begin
            shr_d  = {rx_s2_q, shr_q[7:1]};
            bcnt_d = DIV_M1;
            bidx_d = bidx_q + 3'd1;
            if (bidx_q == 3'd7) bst_d = STOP;
          end
        end
        STOP: begin
          if (!tick) begin
            bcnt_d = bcnt_q - 1'b1;
          end else begin
            bst_d      = IDLE;
            byte_vld_d = rx_s2_q;
            ferr       = ~rx_s2_q;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      bst_q      <= IDLE;
      bcnt_q     <= '0;
      bidx_q     <= '0;
      shr_q      <= '0;
      byte_vld_q <= 1'b0;
    end else begin
      bst_q      <= bst_d;
      bcnt_q     <= bcnt_d;
      bidx_q     <= bidx_d;
      shr_q      <= shr_d;
      byte_vld_q <= byte_vld_d;
    end
  end

  pkt_st_e       pst_q, pst_d;
  logic [7:0]    lcnt_q, lcnt_d;
  logic [7:0]    sum_q, sum_d;
  logic [PW-1:0] wr_tmp_q, wr_tmp_d;
  logic [PW-1:0] wr_cmt_q, wr_cmt_d;
  logic [PW-1:0] pub_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic          pkt_ok_q, pkt_ok_d;
  logic          pkt_err_q, pkt_err_d;
  logic [2:0]    err_code_q, err_code_d;
  logic          we;
  logic [8:0]    wdata;
  logic [PW-1:0] used;
  logic          full;
  logic          to_hit;

`ifdef RS485_RX_TIMEOUT_EN
  localparam int TW = $clog2(16 * BIT_DIV);
  localparam logic [TW-1:0] TO_HIT = TW'(16 * BIT_DIV - 2);
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          to_run;

  always_comb begin
    to_run   = cfg_en && (pst_q != S_HEAD) && !byte_vld_q;
    to_cnt_d = to_run ? to_cnt_q + 1'b1 : '0;
    to_hit   = to_run && (to_cnt_q == TO_HIT);
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) to_cnt_q <= '0;
    else        to_cnt_q <= to_cnt_d;
  end
`else
  assign to_hit = 1'b0;
`endif

  always_comb begin
    pst_d      = pst_q;
    lcnt_d     = lcnt_q;
    sum_d      = sum_q;
    wr_tmp_d   = wr_tmp_q;
    wr_cmt_d   = wr_cmt_q;
    pkt_ok_d   = 1'b0;
    pkt_err_d  = 1'b0;
    err_code_d = err_code_q;
    we         = 1'b0;
    wdata      = {lcnt_q == 8'd1, shr_q};
    used       = wr_tmp_q - rd_ptr_q;
    full       = (used == PW'(DEPTH));
    if (!cfg_en) begin
      pst_d    = S_HEAD;
      wr_tmp_d = wr_cmt_q;
    end else if (ferr || to_hit) begin
      pkt_err_d  = 1'b1;
      err_code_d = ferr ? 3'd1 : 3'd5;
      pst_d      = S_HEAD;
      wr_tmp_d   = wr_cmt_q;
    end else if (byte_vld_q) begin
      unique case (pst_q)
        S_HEAD: begin
          if (shr_q == HDR_BYTE) pst_d = S_LEN;
        end
        S_LEN: begin
          if (shr_q == 8'd0 || shr_q > 8'(MAX_LEN)) begin
            pkt_err_d  = 1'b1;
            err_code_d = 3'd2;
            pst_d      = S_HEAD;
          end else begin
            sum_d  = shr_q;
            lcnt_d = shr_q;
            pst_d  = S_DATA;
          end
        end
        S_DATA: begin
          if (full) begin
            pkt_err_d  = 1'b1;
            err_code_d = 3'd4;
            pst_d      = S_HEAD;
            wr_tmp_d   = wr_cmt_q;
          end else begin
            we       = 1'b1;
            sum_d    = sum_q + shr_q;
            wr_tmp_d = wr_tmp_q + 1'b1;
            lcnt_d   = lcnt_q - 8'd1;
            if (lcnt_q == 8'd1) pst_d = S_SUM;
          end
        end
        S_SUM: begin
          pst_d = S_HEAD;
          if (shr_q == sum_q) begin
            wr_cmt_d = wr_tmp_q;
            pkt_ok_d = 1'b1;
          end else begin
            pkt_err_d  = 1'b1;
            err_code_d = 3'd3;
            wr_tmp_d   = wr_cmt_q;
          end
        end
      endcase
    end
  end

  assign dout_vld = (rd_ptr_q != pub_q);
  assign rd_ptr_d = rd_ptr_q + PW'(dout_vld & dout_rdy);

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      pst_q      <= S_HEAD;
      lcnt_q     <= '0;
      sum_q      <= '0;
      wr_tmp_q   <= '0;
      wr_cmt_q   <= '0;
      pub_q      <= '0;
      rd_ptr_q   <= '0;
      pkt_ok_q   <= 1'b0;
      pkt_err_q  <= 1'b0;
      err_code_q <= '0;
    end else begin
      pst_q      <= pst_d;
      lcnt_q     <= lcnt_d;
      sum_q      <= sum_d;
      wr_tmp_q   <= wr_tmp_d;
      wr_cmt_q   <= wr_cmt_d;
      pub_q      <= wr_cmt_q;
      rd_ptr_q   <= rd_ptr_d;
      pkt_ok_q   <= pkt_ok_d;
      pkt_err_q  <= pkt_err_d;
      err_code_q <= err_code_d;
    end
  end

  // Payload store; the published pointer lags commit so data shows after pkt_ok.
  logic [8:0] mem_q [DEPTH];
  logic [8:0] rdata;

  always_ff @(posedge clk_sys) begin
    if (we) mem_q[wr_tmp_q[FIFO_AW-1:0]] <= wdata;
  end

  assign rdata    = mem_q[rd_ptr_q[FIFO_AW-1:0]];
  assign dout     = dout_vld ? rdata[7:0] : 8'h00;
  assign dout_eop = dout_vld & rdata[8];
  assign pkt_ok   = pkt_ok_q;
  assign pkt_err  = pkt_err_q;
  assign err_code = err_code_q;
  assign fifo_cnt = pub_q - rd_ptr_q;

endmodule

// File: tb/tb_rs485_rx_deframer.sv
// Randomized + directed bench for rs485_rx_deframer with a packet-level
// reference model of the line byte stream.
module tb_rs485_rx_deframer;

  localparam int B     = 24;
  localparam int AW    = 6;
  localparam int ML    = 32;
  localparam int DEPTH = 1 << AW;
  localparam logic [7:0] HDR = 8'hA5;

  typedef logic [7:0] q8_t [$];

  logic         clk_sys = 1'b0;
  logic         rst_n;
  logic         rx_a;
  logic         cfg_en;
  logic [7:0]   dout;
  logic         dout_eop;
  logic         dout_vld;
  logic         dout_rdy;
  logic         pkt_ok;
  logic         pkt_err;
  logic [2:0]   err_code;
  logic [AW:0]  fifo_cnt;

  rs485_rx_deframer #(
    .BIT_DIV (B),
    .FIFO_AW (AW),
    .MAX_LEN (ML),
    .HDR_BYTE(HDR)
  ) dut (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .rx_a    (rx_a),
    .cfg_en  (cfg_en),
    .dout    (dout),
    .dout_eop(dout_eop),
    .dout_vld(dout_vld),
    .dout_rdy(dout_rdy),
    .pkt_ok  (pkt_ok),
    .pkt_err (pkt_err),
    .err_code(err_code),
    .fifo_cnt(fifo_cnt)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc++;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];
  int         got_err[$];
  int         exp_err[$];
  int         err_t[$];
  int         got_ok = 0;
  int         exp_ok = 0;
  bit         vld_seen = 0;
  bit         hold = 0;
  bit         ok_prev = 0;
  logic [9:0] hold_v;
  bit         rdy_rand = 0;
  q8_t        stim;

  always @(negedge clk_sys) begin
    if (rst_n) begin
      if (hold) chk("stable", {dout_vld, dout_eop, dout}, hold_v);
      if (ok_prev) chk("vld_after_ok", dout_vld, 1);
      hold    = dout_vld & ~dout_rdy;
      hold_v  = {dout_vld, dout_eop, dout};
      ok_prev = pkt_ok;
      if (dout_vld) vld_seen = 1;
      if (dout_vld && dout_rdy) got_q.push_back({dout_eop, dout});
      if (pkt_ok) got_ok++;
      if (pkt_err) begin
        got_err.push_back(int'(err_code));
        err_t.push_back(cyc);
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk_sys);
      #1;
      if (rdy_rand) dout_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  task automatic cyc_wait(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic line_bit(input logic v);
    rx_a = v;
    cyc_wait(B);
  endtask

  task automatic send_byte(input logic [7:0] b, input bit bad_stop);
    line_bit(1'b0);
    for (int i = 0; i < 8; i++) line_bit(b[i]);
    line_bit(!bad_stop);
    if (bad_stop) begin
      line_bit(1'b1);
      line_bit(1'b1);
    end
  endtask

  task automatic send_stream(input q8_t s, input int bad, input bit gaps);
    for (int i = 0; i < s.size(); i++) begin
      if (gaps && $urandom_range(0, 3) == 0) cyc_wait($urandom_range(1, 40));
      send_byte(s[i], i == bad);
    end
  endtask

  task automatic add_pkt(input int len, input bit bad_sum);
    logic [7:0] sum;
    logic [7:0] b;
    stim.push_back(HDR);
    stim.push_back(8'(len));
    sum = 8'(len);
    for (int k = 0; k < len; k++) begin
      b = 8'($urandom_range(0, 255));
      if (b == HDR) b = 8'h5A;
      stim.push_back(b);
      sum = sum + b;
    end
    if (sum == HDR) begin
      b   = stim.pop_back();
      sum = sum - b;
      b   = (b == 8'hA4) ? 8'h00 : b + 8'h01;
      stim.push_back(b);
      sum = sum + b;
    end
    stim.push_back(bad_sum ? sum ^ 8'h01 : sum);
  endtask

  // Packet-level view of the stream: which packets commit, which errors fire.
  task automatic model(input q8_t s, input int bad, input int cap);
    int i = 0;
    int n = s.size();
    int used = 0;
    int len, ev_bad, ev_ov;
    logic [7:0] sum;
    while (i < n) begin
      if (i == bad) begin exp_err.push_back(1); i++; continue; end
      if (s[i] != HDR) begin i++; continue; end
      i++;
      if (i >= n) break;
      if (i == bad) begin exp_err.push_back(1); i++; continue; end
      len = int'(s[i]);
      i++;
      if (len == 0 || len > ML) begin exp_err.push_back(2); continue; end
      ev_bad = (bad >= i && bad <= i + len) ? bad : 1 << 30;
      ev_ov  = (used + len > cap) ? i + cap - used : 1 << 30;
      if (ev_bad <= ev_ov && ev_bad < (1 << 30)) begin
        exp_err.push_back(1);
        i = ev_bad + 1;
        continue;
      end
      if (ev_ov < (1 << 30)) begin
        exp_err.push_back(4);
        i = ev_ov + 1;
        continue;
      end
      if (i + len >= n) break;
      sum = 8'(len);
      for (int k = 0; k < len; k++) sum = sum + s[i + k];
      if (s[i + len] != sum) begin
        exp_err.push_back(3);
      end else begin
        for (int k = 0; k < len; k++)
          exp_q.push_back({k == len - 1, s[i + k]});
        used += len;
        exp_ok++;
      end
      i += len + 1;
    end
  endtask

  task automatic clear_all();
    got_q.delete();
    exp_q.delete();
    got_err.delete();
    exp_err.delete();
    err_t.delete();
    got_ok   = 0;
    exp_ok   = 0;
    vld_seen = 0;
  endtask

  task automatic end_scen(input string tag);
    for (int k = 0; k < 4000; k++) begin
      @(negedge clk_sys);
      if (!dout_vld && k > 4) break;
    end
    chk({tag, " cnt0"}, 32'(fifo_cnt), 0);
    chk({tag, " ok"}, got_ok, exp_ok);
    chk({tag, " nerr"}, got_err.size(), exp_err.size());
    for (int k = 0; k < exp_err.size() && k < got_err.size(); k++)
      chk({tag, " err"}, got_err[k], exp_err[k]);
    if (exp_err.size() > 0)
      chk({tag, " code"}, err_code, exp_err[exp_err.size() - 1]);
    chk({tag, " nbyte"}, got_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      chk({tag, " byte"}, got_q[k], exp_q[k]);
    clear_all();
  endtask

  task automatic cfg_pulse();
    cfg_en = 1'b0;
    cyc_wait(3);
    cfg_en = 1'b1;
    cyc_wait(2);
  endtask

  initial begin
    int t_end, d, npk, r;
    rst_n    = 1'b0;
    rx_a     = 1'b1;
    cfg_en   = 1'b1;
    dout_rdy = 1'b1;
    cyc_wait(3);
    @(negedge clk_sys);
    chk("rst vld", dout_vld, 0);
    chk("rst dout", {dout_eop, dout}, 0);
    chk("rst ok", pkt_ok, 0);
    chk("rst err", {pkt_err, err_code}, 0);
    chk("rst cnt", fifo_cnt, 0);
    rst_n = 1'b1;
    cyc_wait(4);

    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    model(stim, -1, 1 << 20);
    send_stream(stim, -1, 0);
    end_scen("good");

    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h6A};
    model(stim, -1, 1 << 20);
    send_stream(stim, -1, 0);
    chk("badsum novld", vld_seen, 0);
    end_scen("badsum");

    stim = '{8'hA5, 8'h00, 8'hA5, 8'h21};
    add_pkt(2, 0);
    model(stim, -1, 1 << 20);
    send_stream(stim, -1, 0);
    end_scen("badlen");

    dout_rdy = 1'b0;
    stim.delete();
    for (int p = 0; p < 3; p++) add_pkt(30, 0);
    model(stim, -1, DEPTH);
    send_stream(stim, -1, 0);
    cyc_wait(4);
    @(negedge clk_sys);
    chk("ovf cnt", fifo_cnt, exp_q.size());
    dout_rdy = 1'b1;
    end_scen("ovf");
    cfg_pulse();

    rx_a = 1'b0;
    cyc_wait(10);
    rx_a = 1'b1;
    cyc_wait(4 * B);
    chk("glitch nerr", got_err.size(), 0);
    chk("glitch novld", vld_seen, 0);
    stim.delete();
    add_pkt(3, 0);
    model(stim, -1, 1 << 20);
    send_stream(stim, -1, 0);
    end_scen("glitch");

    stim = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    model(stim, 3, 1 << 20);
    send_stream(stim, 3, 0);
    chk("frm novld", vld_seen, 0);
    end_scen("frame");

    stim = '{8'hA5, 8'h03, 8'h11};
    send_stream(stim, -1, 0);
    cfg_pulse();
    cyc_wait(2 * B);
    chk("cfg nerr", got_err.size(), 0);
    chk("cfg novld", vld_seen, 0);
    stim.delete();
    add_pkt(4, 0);
    model(stim, -1, 1 << 20);
    send_stream(stim, -1, 0);
    end_scen("cfg");

    stim = '{8'hA5, 8'h03, 8'h11};
    send_stream(stim, -1, 0);
    t_end = cyc;
    cyc_wait(18 * B);
    @(negedge clk_sys);
`ifdef RS485_RX_TIMEOUT_EN
    chk("to n", got_err.size(), 1);
    if (got_err.size() > 0) begin
      chk("to code", got_err[0], 5);
      d = err_t[0] - t_end;
      chk("to win", (d >= 16 * B - B / 2 && d <= 16 * B), 1);
    end
`else
    chk("noto n", got_err.size(), 0);
`endif
    chk("to novld", vld_seen, 0);
    cfg_pulse();
    clear_all();

    for (int sc = 0; sc < 3; sc++) begin
      stim.delete();
      npk = $urandom_range(3, 5);
      for (int p = 0; p < npk; p++) begin
        r = $urandom_range(0, 9);
        if (r == 0) begin
          stim.push_back(8'($urandom_range(0, 8'hA4)));
        end else if (r == 1) begin
          stim.push_back(HDR);
          stim.push_back($urandom_range(0, 1) ? 8'h00
                                              : 8'($urandom_range(33, 255)));
        end else begin
          add_pkt($urandom_range(1, 6), r == 2);
        end
      end
      model(stim, -1, 1 << 20);
      rdy_rand = 1;
      send_stream(stim, -1, 1);
      rdy_rand = 0;
      cyc_wait(1);
      dout_rdy = 1'b1;
      end_scen("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/rs485_rx_deframer.md
Name: rs485_rx_deframer

Overview:
- Master-side receiver for the RS-485 return line `rx_a`, which is driven by the slave's `tx_a`.
- Recovers UART-style bytes from the line, then parses them into packets: header, length, payload, checksum.
- Only packets with a correct checksum are committed to an internal FIFO.
- The FIFO feeds the data-SPI egress path over a valid/ready byte stream with end-of-packet marking.

Parameters:
- BIT_DIV, 100: clk_sys cycles per line bit (1 Mbps at 100 MHz); minimum 8.
- FIFO_AW, 6: FIFO address width; depth = 2^FIFO_AW entries of 9 bits (8 data bits + eop).
- MAX_LEN, 32: largest legal payload length in bytes; must be ≤ 2^FIFO_AW − 1.
- HDR_BYTE, 8'hA5: packet header value.

Ports:
- clk_sys  in  1  system clock (100 MHz).
- rst_n  in  1  asynchronous active-low reset.
- rx_a  in  1  serial line; idles high.
- cfg_en  in  1  receiver enable.
- dout  out  8  payload byte.
- dout_eop  out  1  marks the last payload byte of a packet.
- dout_vld  out  1  output data valid.
- dout_rdy  in  1  consumer ready.
- pkt_ok  out  1  one-cycle pulse when a packet is committed.
- pkt_err  out  1  one-cycle pulse when a packet is discarded.
- err_code  out  3  cause of the last error; held until the next error.
- fifo_cnt  out  FIFO_AW+1  number of committed entries not yet read.

Behaviour:
- Reset: every output is 0, FIFO is empty, and all FSMs are in IDLE / S_HEAD.
- Line sampling: `rx_a` passes through a 2-FF synchroniser, with reset value 1.
- Bit FSM, states IDLE → START → DATA → STOP:
  - IDLE: a falling edge moves to START. The counter waits BIT_DIV/2 cycles, then samples.
  - START: a sample of 1 is a false start → back to IDLE, no byte, no error.
  - DATA: 8 samples taken every BIT_DIV cycles, LSB first.
  - STOP: sampled BIT_DIV cycles after bit 7. A 1 produces `byte_vld` for one cycle. A 0 is a framing error, code 1.
  - Return to IDLE right after the stop sample. Back-to-back frames with zero idle time must be accepted.
- Packet FSM, states S_HEAD / S_LEN / S_DATA / S_SUM, advancing on each `byte_vld`:
  - S_HEAD: a byte equal to HDR_BYTE → S_LEN; any other byte is dropped silently.
  - S_LEN: a length of 0 or greater than MAX_LEN → error code 2, back to S_HEAD. Otherwise sum = len, cnt = len → S_DATA.
  - S_DATA: write {eop = (cnt==1), byte} at `wr_tmp` and add the byte to sum (mod 256).
    - `wr_tmp` then increments and cnt decrements; cnt==1 → S_SUM.
    - If the FIFO has no free entry (`wr_tmp` would reach `rd_ptr`): error code 4, rewind, go to S_HEAD.
  - S_SUM: the received byte equal to sum → `wr_commit <= wr_tmp` and pulse `pkt_ok`. Otherwise error code 3, rewind.
  - Both outcomes return to S_HEAD.
- Rewind: `wr_tmp <= wr_commit`. Uncommitted bytes are never visible on the output.
- Any error:
  - `pkt_err` pulses for one cycle, in the cycle after the error-causing byte or stop sample.
  - `err_code` is updated in the same cycle.
  - The packet FSM returns to S_HEAD.
- Output side (first-word fall-through):
  - `dout_vld = (rd_ptr != wr_commit)`; `{dout_eop, dout}` comes from mem[rd_ptr].
  - A transfer happens on `dout_vld & dout_rdy`, and `rd_ptr` increments.
  - While `dout_vld & ~dout_rdy`, `dout` and `dout_eop` must stay stable.
  - The first byte of a committed packet is visible 1 cycle after the `pkt_ok` pulse.
- Pointers are FIFO_AW+1 bits wide with wrap-around. `fifo_cnt = wr_commit − rd_ptr`.
- A read and a commit in the same cycle are both honoured.
- cfg_en = 0:
  - Bit and packet FSMs are forced to IDLE / S_HEAD and any packet in progress is rewound.
  - No `pkt_err` is generated.
  - Committed data stays readable.
- Asynchronous reset mid-packet: everything is cleared, and partial data is lost.

Optional Feature:
- Macro: RS485_RX_TIMEOUT_EN.
- Enabled: an inter-byte counter runs while the packet FSM is outside S_HEAD.
  - It is cleared on every `byte_vld`.
  - When it reaches 16·BIT_DIV cycles: rewind, `pkt_err` with code 5, return to S_HEAD.
- Disabled: no counter is built. A truncated packet stays pending until further bytes arrive, and code 5 is never produced.

Test Plan:
- Good packet: line bytes A5 03 11 22 33 69, `dout_rdy` = 1 → `pkt_ok` pulses once; 11, 22, 33 are output with `dout_eop` = 1 only on 33; `fifo_cnt` returns to 0.
- Bad checksum: A5 03 11 22 33 6A → `pkt_err` with `err_code` = 3; `dout_vld` never rises; `fifo_cnt` stays 0.
- Bad length: A5 00, then A5 21 with MAX_LEN = 32 → `pkt_err` code 2 twice; a following good packet is received correctly.
- Overflow: `dout_rdy` = 0, FIFO_AW = 6, send 3 packets of len 30 → first two commit (`fifo_cnt` = 60); third gives code 4. After releasing `dout_rdy`, exactly 60 bytes are read with the correct eop positions.
- Line faults:
  - Start-bit glitch (`rx_a` low for 10 cycles) → no byte and no error.
  - Stop bit forced 0 in the middle of a payload → code 1, packet discarded.
  - `cfg_en` toggled low mid-packet → no output, no error.
- Timeout, RS485_RX_TIMEOUT_EN defined: A5 03 11, then idle → `pkt_err` code 5 exactly 16·BIT_DIV cycles after the last `byte_vld`. With the macro undefined, no error occurs.
